wb_stream_bridge: RTL and testbench

//   Byte-stream-to-Wishbone debug initiator. Accepts read/write commands as a valid/ready byte

---
 rtl/wb_stream_bridge_if.sv | 27 ++
 rtl/wb_stream_bridge.sv | 152 +++++++++++++++
 tb/tb_wb_stream_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stream_bridge_if.sv
// wb_stream_bridge_if: command byte stream, response byte stream and Wishbone initiator signals of the bridge
interface wb_stream_bridge_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;
  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, dat_i, ack_i, err_i, rty_i,
    output rx_ready_o, tx_data_o, tx_valid_o, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
  );
  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, dat_i, ack_i, err_i, rty_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
  );
endinterface

// File: rtl/wb_stream_bridge.sv
// wb_stream_bridge: byte-stream commands to single classic Wishbone cycles, byte responses back.
// Define WB_BRIDGE_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES unterminated cycles.
module wb_stream_bridge
`ifdef WB_BRIDGE_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic               clk_i,
  input  logic               rst_ni,
  wb_stream_bridge_if.master bus,
  output logic               busy_o
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
  state_t      r_state, w_state;
  logic [1:0]  r_cnt, w_cnt;
  logic        r_wr, w_wr, r_we, w_we, r_cyc, w_cyc, r_txv, w_txv, r_rxr, r_busy;
  logic [31:0] r_adr, w_adr, r_dat, w_dat;
  logic [39:0] r_tx, w_tx;
  logic [2:0]  r_left, w_left;
  logic        w_rx, w_txd, w_term, w_rd_ok;
  logic [7:0]  w_status;
`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] r_tcnt, w_tcnt;
`endif
  assign w_rx     = bus.rx_valid_i & r_rxr;
  assign w_txd    = r_txv & bus.tx_ready_i;
  assign w_term   = bus.ack_i | bus.err_i | bus.rty_i;
  assign w_status = bus.err_i ? 8'h01 : bus.rty_i ? 8'h02 : 8'h00;
  assign w_rd_ok  = ~bus.err_i & ~bus.rty_i & ~r_we;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_wr    = r_wr;
    w_we    = r_we;
    w_cyc   = r_cyc;
    w_adr   = r_adr;
    w_dat   = r_dat;
    w_tx    = r_tx;
    w_left  = r_left;
    w_txv   = r_txv;
`ifdef WB_BRIDGE_TIMEOUT_EN
    w_tcnt  = '0;
`endif
    case (r_state)
      IDLE: if (w_rx) begin
        if (bus.rx_data_i == 8'h01 || bus.rx_data_i == 8'h02) begin
          w_state = ADDR;
          w_wr    = ~bus.rx_data_i[1];
        end else begin
          w_state = RESP;
          w_txv   = 1'b1;
          w_tx    = {8'h04, 32'h0};
          w_left  = 3'd0;
        end
      end
      ADDR: if (w_rx) begin
        w_adr = {r_adr[23:0], bus.rx_data_i};
        w_cnt = r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          w_state = r_wr ? DATA : BUS;
          w_cyc   = ~r_wr;
        end
      end
      DATA: if (w_rx) begin
        w_dat = {r_dat[23:0], bus.rx_data_i};
        w_cnt = r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          w_state = BUS;
          w_cyc   = 1'b1;
          w_we    = 1'b1;
        end
      end
      BUS: if (w_term) begin
        w_state = RESP;
        w_cyc   = 1'b0;
        w_we    = 1'b0;
        w_txv   = 1'b1;
        w_tx    = w_rd_ok ? {8'h00, bus.dat_i} : {w_status, 32'h0};
        w_left  = w_rd_ok ? 3'd4 : 3'd0;
      end
`ifdef WB_BRIDGE_TIMEOUT_EN
      else if (r_tcnt == TMAX) begin
        w_state = RESP;
        w_cyc   = 1'b0;
        w_we    = 1'b0;
        w_txv   = 1'b1;
        w_tx    = {8'h03, 32'h0};
        w_left  = 3'd0;
      end else w_tcnt = r_tcnt + 1'b1;
`endif
      RESP: if (w_txd) begin
        if (r_left == 3'd0) begin
          w_state = IDLE;
          w_txv   = 1'b0;
        end else begin
          w_tx   = {r_tx[31:0], 8'h00};
          w_left = r_left - 3'd1;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_we    <= 1'b0;
      r_cyc   <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_tx    <= '0;
      r_left  <= '0;
      r_txv   <= 1'b0;
      r_rxr   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
      r_tcnt  <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_wr    <= w_wr;
      r_we    <= w_we;
      r_cyc   <= w_cyc;
      r_adr   <= w_adr;
      r_dat   <= w_dat;
      r_tx    <= w_tx;
      r_left  <= w_left;
      r_txv   <= w_txv;
      r_rxr   <= (w_state == IDLE) || (w_state == ADDR) || (w_state == DATA);
      r_busy  <= w_state != IDLE;
`ifdef WB_BRIDGE_TIMEOUT_EN
      r_tcnt  <= w_tcnt;
`endif
    end
  end
  assign bus.rx_ready_o = r_rxr;
  assign bus.tx_data_o  = r_tx[39:32];
  assign bus.tx_valid_o = r_txv;
  assign bus.cyc_o      = r_cyc;
  assign bus.stb_o      = r_cyc;
  assign bus.we_o       = r_we;
  assign bus.adr_o      = r_adr;
  assign bus.sel_o      = {4{r_cyc}};
  assign bus.dat_o      = r_dat;
  assign busy_o         = r_busy;
endmodule

// File: tb/tb_wb_stream_bridge.sv
// tb_wb_stream_bridge: directed and randomized commands checked against a response-level model
module tb_wb_stream_bridge;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] cmd_q[$];
  int o_cyc_len, o_proto_bad, o_unstable, o_rn;
  logic o_hang, o_txv_first, o_end_rxr, o_we;
  logic [31:0] o_adr, o_dat;
  logic [3:0] o_sel;
  logic [39:0] o_rv;
  int e_n;
  logic [39:0] e_v;
  wb_stream_bridge_if bif();
`ifdef WB_BRIDGE_TIMEOUT_EN
  wb_stream_bridge #(.TIMEOUT_CYCLES(TMO)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bif), .busy_o(busy));
`else
  wb_stream_bridge dut (.clk_i(clk), .rst_ni(rst_n), .bus(bif), .busy_o(busy));
`endif
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end
  // Expected response bytes, packed oldest-first into e_v, count in e_n
  task automatic model(input logic [7:0] op, input logic [2:0] term, input logic [31:0] rd, input bit tmo);
    e_n = 1;
    e_v = 40'h0;
    if (op != 8'h01 && op != 8'h02) e_v = 40'h04;
    else if (tmo) e_v = 40'h03;
    else if (term[2]) e_v = 40'h01;
    else if (term[1]) e_v = 40'h02;
    else if (op == 8'h02) begin
      e_n = 5;
      e_v = {8'h00, rd};
    end
  endtask
  task automatic send_bytes(input bit gaps);
    int g;
    o_hang = 1'b0;
    foreach (cmd_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bif.rx_valid_i = 1'b0;
        @(negedge clk);
      end
      bif.rx_valid_i = 1'b1;
      bif.rx_data_i = cmd_q[i];
      g = 0;
      while (!bif.rx_ready_o && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) o_hang = 1'b1;
      @(negedge clk);
    end
    bif.rx_valid_i = 1'b0;
  endtask
  task automatic bus_phase(input logic [2:0] term, input int lat, input logic [31:0] rd);
    int g = 0;
    o_cyc_len = 0;
    o_proto_bad = 0;
    {o_adr, o_dat, o_we, o_sel} = '0;
    while (bif.cyc_o && g < 2000) begin
      if (o_cyc_len == 0) {o_adr, o_dat, o_we, o_sel} = {bif.adr_o, bif.dat_o, bif.we_o, bif.sel_o};
      else if ({bif.adr_o, bif.dat_o, bif.we_o, bif.sel_o} !== {o_adr, o_dat, o_we, o_sel}) o_proto_bad++;
      if (bif.rx_ready_o || !busy || !bif.stb_o) o_proto_bad++;
      o_cyc_len++;
      bif.rx_valid_i = 1'b1;
      bif.rx_data_i = 8'($urandom);
      {bif.err_i, bif.rty_i, bif.ack_i} = (o_cyc_len == lat) ? term : 3'b000;
      bif.dat_i = (o_cyc_len == lat) ? rd : $urandom;
      @(negedge clk);
      g++;
    end
    if (g >= 2000) o_hang = 1'b1;
    {bif.err_i, bif.rty_i, bif.ack_i} = 3'b000;
  endtask
  task automatic resp_phase(input int stall_first, input bit rnd);
    int g = 0;
    int stall = stall_first;
    bit prev_st = 1'b0;
    logic [7:0] prev = 8'h0;
    o_rn = 0;
    o_rv = '0;
    o_unstable = 0;
    o_txv_first = bif.tx_valid_o;
    while (bif.tx_valid_o && g < 500) begin
      if (prev_st && bif.tx_data_o !== prev) o_unstable++;
      if (bif.rx_ready_o || bif.cyc_o || !busy) o_proto_bad++;
      bif.tx_ready_i = (stall > 0) ? 1'b0 : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall > 0) stall--;
      if (bif.tx_ready_i) begin
        o_rn++;
        o_rv = {o_rv[31:0], bif.tx_data_o};
      end
      prev_st = !bif.tx_ready_i;
      prev = bif.tx_data_o;
      @(negedge clk);
      g++;
    end
    if (g >= 500) o_hang = 1'b1;
    bif.tx_ready_i = 1'b0;
    bif.rx_valid_i = 1'b0;
    o_end_rxr = bif.rx_ready_o && !busy;
  endtask
  task automatic run(input logic [2:0] term, input int lat, input logic [31:0] rd, input int stall_first, input bit rnd);
    send_bytes(rnd);
    bus_phase(term, lat, rd);
    resp_phase(stall_first, rnd);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({bif.cyc_o, bif.stb_o, bif.we_o, bif.tx_valid_o, bif.rx_ready_o, busy, bif.sel_o, bif.adr_o, bif.dat_o, bif.tx_data_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got cyc=%b rxr=%b busy=%b adr=%h, want all zero", bif.cyc_o, bif.rx_ready_o, busy, bif.adr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bif.rx_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_rxr: got %b, want 0", bif.rx_ready_o);
    end
    @(negedge clk);
    n_cmp++;
    if ({bif.rx_ready_o, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_first_edge: got rxr=%b busy=%b, want rxr=1 busy=0", bif.rx_ready_o, busy);
    end
  endtask
  task automatic test_write;
    cmd_q = '{8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    run(3'b001, 2, 32'h0, 0, 1'b0);
    model(8'h01, 3'b001, 32'h0, 1'b0);
    n_cmp++;
    if ({o_adr, o_dat, o_we, o_sel} !== {32'h4000_0000, 32'h3, 1'b1, 4'hF}) begin
      n_bad++;
      $display("FAIL wr_bus: got adr=%h dat=%h we=%b sel=%h, want 40000000 00000003 1 f", o_adr, o_dat, o_we, o_sel);
    end
    n_cmp++;
    if (o_cyc_len != 2) begin
      n_bad++;
      $display("FAIL wr_cyc_len: got %0d, want 2", o_cyc_len);
    end
    n_cmp++;
    if (o_rn != e_n || o_rv !== e_v) begin
      n_bad++;
      $display("FAIL wr_resp: got %0d bytes %h, want %0d bytes %h", o_rn, o_rv, e_n, e_v);
    end
    n_cmp++;
    if (o_proto_bad != 0 || o_hang || !o_txv_first || !o_end_rxr) begin
      n_bad++;
      $display("FAIL wr_proto: got bad=%0d hang=%b txv_first=%b end_rxr=%b, want 0 0 1 1", o_proto_bad, o_hang, o_txv_first, o_end_rxr);
    end
  endtask
  task automatic test_read(input string tag, input int stall_first);
    cmd_q = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h10};
    run(3'b001, 1, 32'hDEAD_BEEF, stall_first, 1'b0);
    model(8'h02, 3'b001, 32'hDEAD_BEEF, 1'b0);
    n_cmp++;
    if ({o_adr, o_we, o_sel, o_cyc_len} !== {32'h1000_0010, 1'b0, 4'hF, 32'd1}) begin
      n_bad++;
      $display("FAIL %s_bus: got adr=%h we=%b sel=%h len=%0d, want 10000010 0 f 1", tag, o_adr, o_we, o_sel, o_cyc_len);
    end
    n_cmp++;
    if (o_rn != e_n || o_rv !== e_v) begin
      n_bad++;
      $display("FAIL %s_resp: got %0d bytes %h, want %0d bytes %h", tag, o_rn, o_rv, e_n, e_v);
    end
    n_cmp++;
    if (o_unstable != 0 || o_proto_bad != 0 || o_hang || !o_txv_first || !o_end_rxr) begin
      n_bad++;
      $display("FAIL %s_proto: got unstable=%0d bad=%0d hang=%b txv_first=%b end_rxr=%b, want 0 0 0 1 1", tag, o_unstable, o_proto_bad, o_hang, o_txv_first, o_end_rxr);
    end
  endtask
  task automatic test_err_ack;
    cmd_q = '{8'h02, 8'h20, 8'h00, 8'h00, 8'h00};
    run(3'b101, 3, 32'h1234_5678, 0, 1'b0);
    model(8'h02, 3'b101, 32'h1234_5678, 1'b0);
    n_cmp++;
    if (o_cyc_len != 3) begin
      n_bad++;
      $display("FAIL err_cyc_len: got %0d, want 3", o_cyc_len);
    end
    n_cmp++;
    if (o_rn != e_n || o_rv !== e_v) begin
      n_bad++;
      $display("FAIL err_resp: got %0d bytes %h, want %0d bytes %h", o_rn, o_rv, e_n, e_v);
    end
  endtask
  task automatic test_bad_opcode;
    cmd_q = '{8'h7F};
    run(3'b001, 1, 32'h0, 0, 1'b0);
    model(8'h7F, 3'b001, 32'h0, 1'b0);
    n_cmp++;
    if (o_cyc_len != 0 || !o_txv_first) begin
      n_bad++;
      $display("FAIL bad_op_bus: got len=%0d txv_first=%b, want 0 1", o_cyc_len, o_txv_first);
    end
    n_cmp++;
    if (o_rn != e_n || o_rv !== e_v || !o_end_rxr) begin
      n_bad++;
      $display("FAIL bad_op_resp: got %0d bytes %h end_rxr=%b, want %0d bytes %h end_rxr=1", o_rn, o_rv, o_end_rxr, e_n, e_v);
    end
    cmd_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    run(3'b001, 1, 32'h0, 0, 1'b0);
    model(8'h01, 3'b001, 32'h0, 1'b0);
    n_cmp++;
    if ({o_adr, o_dat, o_we, o_cyc_len} !== {32'h4, 32'h1122_3344, 1'b1, 32'd1}) begin
      n_bad++;
      $display("FAIL after_bad_bus: got adr=%h dat=%h we=%b len=%0d, want 00000004 11223344 1 1", o_adr, o_dat, o_we, o_cyc_len);
    end
    n_cmp++;
    if (o_rn != e_n || o_rv !== e_v) begin
      n_bad++;
      $display("FAIL after_bad_resp: got %0d bytes %h, want %0d bytes %h", o_rn, o_rv, e_n, e_v);
    end
  endtask
  task automatic test_long_wait;
    cmd_q = '{8'h01, 8'hA0, 8'h00, 8'h00, 8'h08, 8'hCA, 8'hFE, 8'h00, 8'h01};
    run(3'b010, 20, 32'h0, 0, 1'b0);
    model(8'h01, 3'b010, 32'h0, 1'b0);
`ifdef WB_BRIDGE_TIMEOUT_EN
    model(8'h01, 3'b010, 32'h0, 1'b1);
`endif
    n_cmp++;
`ifdef WB_BRIDGE_TIMEOUT_EN
    if (o_cyc_len != TMO + 1) begin
      n_bad++;
      $display("FAIL long_cyc_len: got %0d, want %0d", o_cyc_len, TMO + 1);
    end
`else
    if (o_cyc_len != 20) begin
      n_bad++;
      $display("FAIL long_cyc_len: got %0d, want 20", o_cyc_len);
    end
`endif
    n_cmp++;
    if (o_rn != e_n || o_rv !== e_v || o_proto_bad != 0) begin
      n_bad++;
      $display("FAIL long_resp: got %0d bytes %h bad=%0d, want %0d bytes %h bad=0", o_rn, o_rv, o_proto_bad, e_n, e_v);
    end
  endtask
`ifdef WB_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    cmd_q = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h00};
    run(3'b000, 0, 32'h0, 0, 1'b0);
    model(8'h02, 3'b000, 32'h0, 1'b1);
    n_cmp++;
    if (o_cyc_len != TMO + 1 || o_rn != e_n || o_rv !== e_v) begin
      n_bad++;
      $display("FAIL timeout: got len=%0d %0d bytes %h, want len=%0d %0d bytes %h", o_cyc_len, o_rn, o_rv, TMO + 1, e_n, e_v);
    end
    run(3'b001, TMO + 1, 32'h0BAD_F00D, 0, 1'b0);
    model(8'h02, 3'b001, 32'h0BAD_F00D, 1'b0);
    n_cmp++;
    if (o_cyc_len != TMO + 1 || o_rn != e_n || o_rv !== e_v) begin
      n_bad++;
      $display("FAIL timeout_ack_wins: got len=%0d %0d bytes %h, want len=%0d %0d bytes %h", o_cyc_len, o_rn, o_rv, TMO + 1, e_n, e_v);
    end
  endtask
`endif
  task automatic test_reset_mid_bus;
    cmd_q = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h10};
    send_bytes(1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bif.cyc_o, bif.stb_o, bif.tx_valid_o, busy, bif.rx_ready_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got cyc=%b stb=%b txv=%b busy=%b rxr=%b, want all 0", bif.cyc_o, bif.stb_o, bif.tx_valid_o, busy, bif.rx_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_read("rd_after_reset_stall", 3);
  endtask
  task automatic test_back_to_back;
    logic [7:0] op;
    logic [31:0] adr, wd, rd;
    logic [2:0] term;
    int lat;
    bit valid;
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ($urandom_range(0, 1) ? 8'h01 : 8'h02);
      adr = $urandom;
      wd = $urandom;
      rd = $urandom;
      term = 3'($urandom_range(1, 7));
      lat = $urandom_range(1, 5);
      valid = (op == 8'h01) || (op == 8'h02);
      cmd_q = {op, adr[31:24], adr[23:16], adr[15:8], adr[7:0]};
      if (op == 8'h01) cmd_q = {cmd_q, wd[31:24], wd[23:16], wd[15:8], wd[7:0]};
      if (!valid) cmd_q = {op};
      run(term, lat, rd, 0, 1'b1);
      model(op, term, rd, 1'b0);
      n_cmp++;
      if (o_cyc_len != (valid ? lat : 0)) begin
        n_bad++;
        $display("FAIL rnd%0d_cyc_len: op=%h got %0d, want %0d", k, op, o_cyc_len, valid ? lat : 0);
      end
      n_cmp++;
      if (valid && {o_adr, o_we, o_sel} !== {adr, op == 8'h01, 4'hF}) begin
        n_bad++;
        $display("FAIL rnd%0d_bus: got adr=%h we=%b sel=%h, want %h %b f", k, o_adr, o_we, o_sel, adr, op == 8'h01);
      end
      n_cmp++;
      if (op == 8'h01 && o_dat !== wd) begin
        n_bad++;
        $display("FAIL rnd%0d_wdata: got %h, want %h", k, o_dat, wd);
      end
      n_cmp++;
      if (o_rn != e_n || o_rv !== e_v) begin
        n_bad++;
        $display("FAIL rnd%0d_resp: op=%h term=%b got %0d bytes %h, want %0d bytes %h", k, op, term, o_rn, o_rv, e_n, e_v);
      end
      n_cmp++;
      if (o_unstable != 0 || o_proto_bad != 0 || o_hang || !o_txv_first || !o_end_rxr) begin
        n_bad++;
        $display("FAIL rnd%0d_proto: got unstable=%0d bad=%0d hang=%b txv_first=%b end_rxr=%b, want 0 0 0 1 1", k, o_unstable, o_proto_bad, o_hang, o_txv_first, o_end_rxr);
      end
    end
  endtask
  initial begin
    bif.rx_valid_i = 1'b0;
    bif.rx_data_i = 8'h0;
    bif.tx_ready_i = 1'b0;
    bif.dat_i = 32'h0;
    {bif.err_i, bif.rty_i, bif.ack_i} = 3'b000;
    test_reset;
    test_write;
    test_read("rd", 0);
    test_err_ack;
    test_bad_opcode;
    test_long_wait;
`ifdef WB_BRIDGE_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid_bus;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
